sample_clk_monitor: RTL and testbench



---
 rtl/sample_clk_monitor_if.sv | 11 +
 rtl/sample_clk_monitor.sv | 97 +++++++++
 tb/tb_sample_clk_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sample_clk_monitor_if.sv
// sample_clk_monitor_if: divided sample clock in, strobe/period/lock/error status out
interface sample_clk_monitor_if #(parameter int PW = 10);
  logic clk_d;
  logic sample_stb;
  logic [PW-1:0] period;
  logic locked;
  logic err_glitch;
  logic err_missing;
  modport master (output clk_d, input sample_stb, period, locked, err_glitch, err_missing);
  modport slave (input clk_d, output sample_stb, period, locked, err_glitch, err_missing);
endinterface

// File: rtl/sample_clk_monitor.sv
// sample_clk_monitor: synchronizes clk_d, strobes each accepted edge, measures period, tracks lock
module sample_clk_monitor #(
  parameter int CLK_HZ = 12_000_000,
  parameter int DESIRED_HZ = 48_000,
  parameter int TOL = 4,
  parameter int LOCK_COUNT = 4
) (
  input logic clk,
  input logic rst,
  sample_clk_monitor_if.slave bus
);
  localparam int EXP = 2 * (CLK_HZ / DESIRED_HZ + 1);
  localparam int PW = $clog2(2 * EXP + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [PW-1:0] cnt, m;
  logic [GW-1:0] good, good_n;
  logic edg, in_rng, early, tmo, stb_n, glitch_n, missing_n;
  assign edg = s2 & ~s3;
  assign m = cnt + PW'(1);
  assign early = m < PW'(EXP - TOL);
  assign in_rng = !early && m <= PW'(EXP + TOL);
  // an edge clears cnt, so a timeout can only be seen on a non-edge cycle
  assign tmo = !edg && cnt == PW'(EXP + TOL);
  assign bus.locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      cnt <= '0;
      good <= '0;
      state <= IDLE;
      bus.sample_stb <= 1'b0;
      bus.err_glitch <= 1'b0;
      bus.err_missing <= 1'b0;
      bus.period <= '0;
    end else begin
      s1 <= bus.clk_d;
      s2 <= s1;
      s3 <= s2;
      cnt <= edg ? '0 : cnt == PW'(2 * EXP) ? cnt : cnt + PW'(1);
      good <= good_n;
      state <= state_n;
      bus.sample_stb <= stb_n;
      bus.err_glitch <= glitch_n;
      bus.err_missing <= missing_n;
      if (edg && state != IDLE) bus.period <= m;
    end
  end
  always_comb begin
    state_n = state;
    good_n = good;
    stb_n = 1'b0;
    glitch_n = 1'b0;
    missing_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (edg) begin
          state_n = ACQUIRE;
          good_n = '0;
        end
      end
      ACQUIRE: begin
        if (edg) begin
          good_n = in_rng ? good + GW'(1) : '0;
          if (in_rng && good_n == GW'(LOCK_COUNT)) begin
            state_n = LOCKED;
            stb_n = 1'b1;
          end
        end else if (tmo) state_n = IDLE;
      end
      LOCKED: begin
        if (edg) begin
          stb_n = in_rng;
          if (early) begin
            glitch_n = 1'b1;
            state_n = ACQUIRE;
            good_n = '0;
          end
        end else if (tmo) begin
          missing_n = 1'b1;
          state_n = LOST;
        end
      end
      LOST: begin
        if (edg) begin
          state_n = ACQUIRE;
          good_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sample_clk_monitor.sv
// tb_sample_clk_monitor: timestamp-based reference model checked every cycle against the monitor
module tb_sample_clk_monitor;
  localparam int EXP = 2 * (12_000_000 / 48_000 + 1);
  localparam int TOL = 4;
  localparam int LC = 4;
  localparam int PW = $clog2(2 * EXP + 1);
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mode_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  mode_t mode = M_IDLE;
  int good = 0;
  int last = 0;
  int per_exp = 0;
  int pend[$];
  bit e_stb, e_gl, e_ms;
  sample_clk_monitor_if #(.PW(PW)) bus ();
  sample_clk_monitor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask
  // expected outputs for the cycle following posedge t, from edge timestamps alone
  task automatic model_step(input int t);
    int m;
    bit inr;
    e_stb = 0;
    e_gl = 0;
    e_ms = 0;
    if (pend.size() > 0 && pend[0] == t) begin
      void'(pend.pop_front());
      m = t - last;
      if (m > 2 * EXP + 1) m = 2 * EXP + 1;
      last = t;
      inr = m >= EXP - TOL && m <= EXP + TOL;
      if (mode == M_IDLE) begin
        mode = M_ACQ;
        good = 0;
      end else begin
        per_exp = m;
        if (mode == M_LOST) begin
          mode = M_ACQ;
          good = 0;
        end else if (mode == M_ACQ) begin
          if (inr) begin
            good++;
            if (good == LC) begin
              mode = M_LOCK;
              e_stb = 1;
            end
          end else good = 0;
        end else if (inr) e_stb = 1;
        else if (m < EXP - TOL) begin
          e_gl = 1;
          mode = M_ACQ;
          good = 0;
        end
      end
    end else if (t - last == EXP + TOL + 1) begin
      if (mode == M_ACQ) mode = M_IDLE;
      else if (mode == M_LOCK) begin
        e_ms = 1;
        mode = M_LOST;
      end
    end
  endtask
  task automatic tick(input bit d, input bit r);
    @(negedge clk);
    if (rst) begin
      mode = M_IDLE;
      good = 0;
      per_exp = 0;
      pend.delete();
      last = cyc;
      e_stb = 0;
      e_gl = 0;
      e_ms = 0;
    end else model_step(cyc);
    chk("sample_stb", 32'(bus.sample_stb), 32'(e_stb));
    chk("err_glitch", 32'(bus.err_glitch), 32'(e_gl));
    chk("err_missing", 32'(bus.err_missing), 32'(e_ms));
    chk("locked", 32'(bus.locked), 32'(mode == M_LOCK));
    chk("period", 32'(bus.period), 32'(per_exp));
    if (d && !bus.clk_d && !r) pend.push_back(cyc + 3);
    bus.clk_d = d;
    rst = r;
  endtask
  task automatic per(input int p);
    for (int i = 0; i < p; i++) tick(i < p / 2, 1'b0);
  endtask
  initial begin
    bus.clk_d = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    repeat (8) per(EXP);
    chk("nominal_locked", 32'(bus.locked), 32'd1);
    chk("nominal_period", 32'(bus.period), 32'(EXP));
    for (int i = 0; i < 6; i++) per(i % 2 ? EXP + TOL : EXP - TOL);
    for (int i = 0; i < 6; i++) per($urandom_range(EXP + TOL, EXP - TOL));
    chk("jitter_locked", 32'(bus.locked), 32'd1);
    per(200);
    per(EXP);
    chk("glitch_period", 32'(bus.period), 32'd200);
    chk("glitch_unlocked", 32'(bus.locked), 32'd0);
    repeat (5) per(EXP);
    chk("glitch_relock", 32'(bus.locked), 32'd1);
    per(150);
    for (int i = 0; i < 3; i++) per($urandom_range(490, 300));
    repeat (6) per(EXP);
    chk("acq_relock", 32'(bus.locked), 32'd1);
    per(1500);
    per(EXP);
    chk("missing_sat_period", 32'(bus.period), 32'(2 * EXP + 1));
    repeat (5) per(EXP);
    chk("missing_relock", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 300; i++) tick(i < EXP / 2, 1'b0);
    tick(1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0);
    repeat (7) per(EXP);
    chk("reset_relock", 32'(bus.locked), 32'd1);
    tick(1'b0, 1'b1);
    repeat (2100) tick(1'b0, 1'b0);
    per(EXP);
    chk("idle_sat_period", 32'(bus.period), 32'd0);
    repeat (5) per(EXP);
    chk("idle_sat_relock", 32'(bus.locked), 32'd1);
    repeat (5) tick(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
